// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter slice.
package common;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DATA,
        OWN_FETCH
    } mem_owner_e;

    typedef enum logic {
        ARB_NORMAL,
        ARB_BOOST
    } arb_state_e;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Requester and SRAM bundle for the unified memory arbiter.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              ld_valid;
    logic [31:0]       ld_addr;
    logic [7:0]        ld_data;
    logic              ld_ready;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_kill;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output ld_valid, ld_addr, ld_data,
        input  ld_ready,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output i_req, i_addr, i_kill,
        input  i_gnt, i_rvalid, i_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data,
        output ld_ready,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  i_req, i_addr, i_kill,
        output i_gnt, i_rvalid, i_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/unified_mem_arbiter_prio3.sv
// Three-way fixed-priority grant; boost lifts fetch above data.
module mem_arb_prio3 (
    input  logic [2:0] req,
    input  logic       boost,
    output logic [2:0] gnt
);

    // req/gnt bits: 0 loader, 1 data, 2 fetch
    always_comb begin
        gnt = 3'b000;
        priority case (1'b1)
            req[0]:           gnt = 3'b001;
            boost && req[2]:  gnt = 3'b100;
            req[1]:           gnt = 3'b010;
            req[2]:           gnt = 3'b100;
            default:          gnt = 3'b000;
        endcase
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port SRAM shared by loader, data port and fetch, with fetch anti-starvation.
module unified_mem_arbiter
    import common::*;
#(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input logic                  clk,
    input logic                  reset,
    unified_mem_arbiter_if.slave bus
);

    localparam int CW = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_e    state;
    mem_owner_e    rsp_owner;
    mem_owner_e    owner_nxt;
    logic          kill_q;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    req;
    logic [2:0]    gnt;
    logic          d_rv;
    logic          i_rv;
    logic          unused_addr;

    assign req = reset ? 3'b000
                       : {bus.i_req, bus.d_req, bus.ld_valid};

    mem_arb_prio3 u_prio (
        .req   (req),
        .boost (state == ARB_BOOST),
        .gnt   (gnt)
    );

    assign bus.ld_ready = gnt[0];
    assign bus.d_gnt    = gnt[1];
    assign bus.i_gnt    = gnt[2];

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (1'b1)
            gnt[0]: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 4'b0001 << bus.ld_addr[1:0];
                bus.mem_addr  = bus.ld_addr[ADDR_W+1:2];
                bus.mem_wdata = {4{bus.ld_data}};
            end
            gnt[1]: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.d_we ? bus.d_be : 4'b0000;
                bus.mem_addr  = bus.d_addr[ADDR_W+1:2];
                bus.mem_wdata = bus.d_we ? bus.d_wdata : '0;
            end
            gnt[2]: begin
                bus.mem_en    = 1'b1;
                bus.mem_addr  = bus.i_addr[ADDR_W+1:2];
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_nxt = OWN_NONE;
        if (gnt[2])
            owner_nxt = OWN_FETCH;
        else if (gnt[1] && !bus.d_we)
            owner_nxt = OWN_DATA;
    end

    always_comb begin
        cnt_nxt = starve_cnt;
        if (!bus.i_req || gnt[2])
            cnt_nxt = '0;
        else if (starve_cnt != LIMIT)
            cnt_nxt = starve_cnt + CW'(1);
    end

    // Boost is entered together with the count saturating, so the
    // very next cycle already ranks fetch above data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_NORMAL;
            starve_cnt <= '0;
            rsp_owner  <= OWN_NONE;
            kill_q     <= 1'b0;
        end else begin
            rsp_owner <= owner_nxt;
            kill_q    <= bus.i_kill && gnt[2];
            unique case (state)
                ARB_NORMAL: begin
                    starve_cnt <= cnt_nxt;
                    if (cnt_nxt == LIMIT)
                        state <= ARB_BOOST;
                end
                ARB_BOOST: begin
                    if (bus.i_kill) begin
                        starve_cnt <= '0;
                        state      <= ARB_NORMAL;
                    end else begin
                        starve_cnt <= cnt_nxt;
                        if (gnt[2])
                            state <= ARB_NORMAL;
                    end
                end
                default: state <= ARB_NORMAL;
            endcase
        end
    end

    assign d_rv = (rsp_owner == OWN_DATA);
    assign i_rv = (rsp_owner == OWN_FETCH) && !kill_q && !bus.i_kill;

    assign bus.d_rvalid = d_rv;
    assign bus.i_rvalid = i_rv;
    assign bus.d_rdata  = d_rv ? bus.mem_rdata : '0;
    assign bus.i_rdata  = i_rv ? bus.mem_rdata : '0;

    assign unused_addr = ^{bus.ld_addr[31:ADDR_W+2],
                           bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0],
                           bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0]};

endmodule
